// File: rtl/inst_fetch_memory.sv
// rtl/inst_fetch_memory.sv - byte-addressed little-endian instruction memory with registered fetch and run-time loader
//
// Purpose: instruction store between the PC register and the IF/ID register.
//   One-cycle registered fetch with stall/flush handling, fault reporting on
//   misaligned or out-of-range fetches, and a programming mode for loading
//   32-bit words at run time.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   fetch_req, stall, flush    fetch control (priority flush > stall > fetch_req)
//   Inst_Address               byte address of the instruction to fetch
//   Instruction                fetched word, little-endian
//   inst_valid, inst_fault     response valid, fault code (00 ok, 01 misaligned, 10 out of range)
//   prog_en, prog_we           programming mode request / write strobe
//   prog_addr, prog_data       word address and data for programming writes
//   busy                       high while in programming mode
//   prog_err                   sticky flag for a bad programming write
module inst_fetch_memory #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned ADDR_W      = 64,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] Inst_Address,
  output logic [31:0]       Instruction,
  output logic              inst_valid,
  output logic [1:0]        inst_fault,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic              busy,
  output logic              prog_err
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  // Highest legal word address; a > LAST_WORD_ADDR is the same as a+3 > DEPTH_BYTES-1
  // but cannot wrap at the top of the address space.
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);

  localparam logic [1:0] FAULT_OK  = 2'b00;
  localparam logic [1:0] FAULT_MIS = 2'b01;
  localparam logic [1:0] FAULT_OOR = 2'b10;

  typedef enum logic {FETCH, PROG} state_e;

  // Stored as whole words: byte a of a word lives in bits [8*(a%4) +: 8],
  // which is exactly the little-endian layout of prog_data.
  logic [31:0] mem_q [WORDS] = '{default: NOP_WORD};

  state_e      state_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [1:0]  fault_q;
  logic        busy_q;
  logic        prog_err_q;

  logic             fetch_mis, fetch_oor;
  logic             prog_ok;
  logic [IDX_W-1:0] fetch_idx, prog_idx;

  assign fetch_mis = (Inst_Address[1:0] != 2'b00);
  assign fetch_oor = (Inst_Address > LAST_WORD_ADDR);
  assign fetch_idx = Inst_Address[IDX_W+1:2];
  assign prog_ok   = (prog_addr[1:0] == 2'b00) && (prog_addr <= LAST_WORD_ADDR);
  assign prog_idx  = prog_addr[IDX_W+1:2];

  // Memory has no reset; a write coinciding with reset is suppressed so that
  // reset never changes contents.
  always_ff @(posedge clk) begin
    if (!reset && state_q == PROG && prog_we && prog_ok) begin
      mem_q[prog_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      fault_q    <= FAULT_OK;
      busy_q     <= 1'b0;
      prog_err_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (prog_en) begin
            // Entering PROG drops any fetch presented this cycle.
            state_q <= PROG;
            busy_q  <= 1'b1;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= FAULT_OK;
          end else if (flush) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= FAULT_OK;
          end else if (stall) begin
            // Hold the IF/ID view; the PC is re-presented by the core.
          end else if (fetch_req) begin
            valid_q <= 1'b1;
            if (fetch_mis) begin
              instr_q <= NOP_WORD;
              fault_q <= FAULT_MIS;
            end else if (fetch_oor) begin
              instr_q <= NOP_WORD;
              fault_q <= FAULT_OOR;
            end else begin
              instr_q <= mem_q[fetch_idx];
              fault_q <= FAULT_OK;
            end
          end else begin
            valid_q <= 1'b0;
          end
        end
        PROG: begin
          if (prog_we && !prog_ok) begin
            prog_err_q <= 1'b1;
          end
          if (!prog_en) begin
            state_q <= FETCH;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= FETCH;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Instruction = instr_q;
  assign inst_valid  = valid_q;
  assign inst_fault  = fault_q;
  assign busy        = busy_q;
  assign prog_err    = prog_err_q;

endmodule

// File: doc/inst_fetch_memory.md
Name: inst_fetch_memory

Overview:
- Parametrised, byte-addressed, little-endian instruction memory for the pipelined RISC-V core, sitting between the PC register and the IF/ID pipeline register.
- Read is registered with 1-cycle latency and supports pipeline stall and flush.
- Returns NOP with a fault code on misaligned or out-of-range fetches.
- Has a programming mode: a loader writes 32-bit words at run time, so test programs need no RTL edit.

Parameters:
DEPTH_BYTES, 256, memory size in bytes; multiple of 4, at least 4
ADDR_W, 64, width of fetch and program addresses
NOP_WORD, 32'h00000013, word returned on fault/flush/reset (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
fetch_req  in  1  fetch request for Inst_Address this cycle
stall  in  1  hold current output (IF/ID stall)
flush  in  1  kill output (branch taken / redirect)
Inst_Address  in  ADDR_W  byte address of instruction
Instruction  out  32  fetched word {mem[a+3],mem[a+2],mem[a+1],mem[a]}
inst_valid  out  1  Instruction holds a fetch response
inst_fault  out  2  00 ok, 01 misaligned, 10 out of range
prog_en  in  1  request/hold programming mode
prog_we  in  1  write strobe in programming mode
prog_addr  in  ADDR_W  byte address of word to write
prog_data  in  32  word to write, stored little-endian
busy  out  1  1 while in PROG state, fetches ignored
prog_err  out  1  sticky: a programming write was misaligned or out of range

Behaviour:
- Reset values: Instruction=NOP_WORD, inst_valid=0, inst_fault=00, busy=0, prog_err=0, state=FETCH.
- Memory contents:
  - At time zero every byte is the matching byte of NOP_WORD.
  - Reset does not alter memory, including reset in the middle of programming. Words already written are kept.
- States: FETCH, PROG.
  - FETCH -> PROG when prog_en=1; a fetch_req in the same cycle is ignored.
  - PROG -> FETCH in the cycle after prog_en=0 is sampled.
  - busy is registered: it equals 1 in every cycle the state is PROG.
- PROG state:
  - inst_valid=0; Instruction held at NOP_WORD; fetch_req, stall and flush ignored.
  - prog_we=1 with a=prog_addr, a[1:0]=0 and a+3<=DEPTH_BYTES-1: write mem[a]=data[7:0] through mem[a+3]=data[31:24] at the clock edge.
  - Any other prog_we: no write, prog_err<=1 (cleared only by reset).
  - prog_we in FETCH state is ignored; no error is flagged.
- FETCH state, priority per cycle is flush > stall > fetch_req:
  - flush=1: next cycle Instruction=NOP_WORD, inst_valid=0, inst_fault=00. Any simultaneous request is dropped.
  - stall=1 (no flush): Instruction, inst_valid and inst_fault hold their values; the request is dropped. The PC is held externally, so it is re-presented.
  - fetch_req=1: the next cycle presents the response for Inst_Address with inst_valid=1 (latency 1).
    - a[1:0]!=0: NOP_WORD with fault 01. Misaligned takes precedence over out of range.
    - a+3>DEPTH_BYTES-1, evaluated on full ADDR_W without wrap: NOP_WORD with fault 10.
    - Otherwise: memory word with fault 00.
  - fetch_req=0: next cycle inst_valid=0; Instruction and inst_fault hold.
- Back-to-back requests give one response per cycle with no bubbles.
- Last valid word address is DEPTH_BYTES-4. Address DEPTH_BYTES-2 reports 01; address DEPTH_BYTES reports 10.

Test Plan:
- Reset then fetch_req=1 at addresses 0,4,8 on consecutive cycles, unprogrammed -> cycles 1..3 show 32'h00000013, inst_valid=1, fault 00.
- prog_en=1; write 32'h00F00713 at addr 4 and 32'h00E53023 at addr 8; prog_en=0; fetch 4 then 8 -> 32'h00F00713 then 32'h00E53023. Byte check: mem[4]=8'h13, mem[7]=8'h00. busy is 1 exactly during PROG.
- With DEPTH_BYTES=256, fetch addresses 252, 254, 256 and 64'hFFFF_FFFF_FFFF_FFFC -> fault 00, 01, 10, 10; the last three return NOP_WORD; no wrap to low memory.
- Fetch addr 4 (valid response), then stall=1 for 3 cycles with Inst_Address=8 -> Instruction stays at the word from 4, inst_valid stays 1. Stall released -> next cycle shows the word at 8.
- flush=1 together with stall=1 and fetch_req=1 -> next cycle inst_valid=0, Instruction=NOP_WORD.
- In PROG: write to addr 2 and to addr 256 -> prog_err=1, memory unchanged. Assert reset during PROG -> state FETCH, busy=0, prog_err=0, previously written words still readable.
